data_pipe_buf: RTL and testbench
================================

// Module: data_pipe_buf
// PURPOSE
//  Parametrised registered data buffer: successor to the single-bit registered in->out path.
//  Generalises to WIDTH-bit words, DEPTH-entry storage and valid/ready handshakes on both sides.
//  Sits between a master-side producer and a slave-side consumer inside the TB/DUT interface layer.
//  Absorbs backpressure without losing data.
// PARAMETERS
//  WIDTH      8  data word width in bits (>=1)
//  DEPTH      4  storage entries; power of 2, >=2
//  AF_THRESH  3  almost_full level threshold (1..DEPTH); used only with DATA_PIPE_BUF_STATUS_EN
// PORTS
//  clk        in   1          single clock, all logic on posedge
//  reset_n    in   1          asynchronous active-low reset
//  flush      in   1          synchronous clear of buffer contents
//  in_valid   in   1          producer word valid
//  in_data    in   WIDTH      producer word
//  in_ready   out  1          buffer can accept a word this cycle
//  out_valid  out  1          out_data holds a valid word
//  out_data   out  WIDTH      oldest stored word
//  out_ready  in   1          consumer accepts word this cycle
//  level      out  $clog2(DEPTH+1)  entries held (STATUS_EN only)
//  almost_full out 1          level >= AF_THRESH (STATUS_EN only)
//  max_level  out  $clog2(DEPTH+1)  high-water mark since reset/clr_stats (STATUS_EN only)
//  clr_stats  in   1          resets max_level to current level (STATUS_EN only)
// BEHAVIOUR
//  Reset (reset_n=0, async): pointers=0, count=0, in_ready=0, out_valid=0, out_data=0; all status outputs 0.
//  First cycle after reset release: in_ready=1.
//  Push = in_valid & in_ready; pop = out_valid & out_ready; each transfer is one word per cycle.
//  in_ready = registered (count < DEPTH); no combinational path from out_ready to in_ready.
//  out_valid = (count != 0).
//  out_data is registered: head word at mem[rd_ptr].
//  Latency: word pushed at edge N into an empty buffer gives out_valid=1 with that data after edge N
//  (visible in cycle N+1).
//  Simultaneous push & pop: count unchanged, both pointers advance, order preserved.
//  Full (count=DEPTH): in_ready=0; a pop at edge N raises in_ready after edge N.
//  Empty: out_valid=0; out_data holds last value (don't-care to consumer).
//  Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0; count tracks full/empty explicitly.
//  flush=1: pointers/count -> 0 at the edge; push/pop in the same cycle are discarded (flush wins).
//  Producer must hold in_valid/in_data until in_ready; data order is strict FIFO, no drops.
//  Reset mid-transfer: all contents discarded immediately (async), no partial word emitted.
// CONFIGURATION
//  Macro DATA_PIPE_BUF_STATUS_EN:
//   defined: level, almost_full, max_level ports and clr_stats input exist.
//    level = count (registered).
//    almost_full = (next count >= AF_THRESH), registered.
//    max_level updates to max(max_level, level) every cycle.
//    clr_stats loads max_level with the current level; flush zeroes level but not max_level.
//   undefined: those ports and their logic are absent; core FIFO behaviour identical.
// STRUCTURE
//  Package data_pipe_buf_pkg: parameterised ptr/count width functions (clog2 helpers), typedef of
//  handshake struct {valid, data}, reset constants.
//  Sub-module data_pipe_buf_mem: DEPTH x WIDTH register array, one write port and one registered
//  read port, no reset on array.
//  Top holds pointers, count, handshake logic and optional status block.
// TESTING (WIDTH=8, DEPTH=4, AF_THRESH=3)
//  1 Reset held 5 cycles, then released -> all outputs 0 during reset; in_ready=1 on first cycle after.
//  2 Push 0x11,0x22,0x33,0x44 with out_ready=0 -> in_ready=0 after 4th push; a 5th word (0x55) is
//    held off and not stored.
//  3 From full, out_ready=1 for 4 cycles -> out_data 0x11,0x22,0x33,0x44 in order; out_valid=0 after.
//  4 Continuous in_valid & out_ready=1 with an incrementing stream 0x00..0x0F -> 16 words out in order;
//    count stays at 1 (steady state, one push and one pop per cycle).
//  5 3 words stored, assert flush together with in_valid=1 (0xAA) -> out_valid=0 next cycle;
//    0xAA never appears at the output.
//  6 STATUS_EN: push 3 words -> almost_full=1, level=3; pop 2 -> level=1, max_level=3; pulse clr_stats
//    -> max_level=1.
//  7 Assert reset_n=0 mid-stream with 2 words stored -> out_valid=0 immediately (async);
//    buffer is empty after release.

Source files
------------

// File: rtl/data_pipe_buf_pkg.sv
// Shared helpers for data_pipe_buf: pointer/count width functions,
// the per-cycle transfer descriptor and reset constants.
package data_pipe_buf_pkg;

   // Width of a pointer that addresses DEPTH entries (never below 1 bit)
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Width of a counter that must represent 0..DEPTH inclusive
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // What happens to the buffer in the current cycle
   typedef struct packed {
      logic push;
      logic pop;
      logic flush;
   } xfer_t;

   // in_ready stays low while reset is held; it rises on the first edge after release
   localparam logic RST_READY = 1'b0;
   localparam logic RST_VALID = 1'b0;

endpackage

// File: rtl/data_pipe_buf_mem.sv
// Storage array for data_pipe_buf: DEPTH x WIDTH registers with one write
// port and one registered read port. The array itself has no reset; only
// the read register does, so out_data reads 0 straight out of reset.
// rd_bypass forwards the word being written this cycle into the read
// register, used when the incoming word becomes the head immediately.
module data_pipe_buf_mem
   import data_pipe_buf_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [ptr_w(DEPTH)-1:0]  wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   input  logic [ptr_w(DEPTH)-1:0]  rd_addr,
   input  logic                     rd_bypass,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store the pushed word at the write pointer
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read port: load the next head word, forwarding a same-cycle write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= rd_bypass ? wr_data : mem[rd_addr];
      end
   end

endmodule

// File: rtl/data_pipe_buf.sv
// data_pipe_buf: registered FIFO buffer with valid/ready on both sides.
// Word pushed into an empty buffer is presented at out_data right after the
// push edge. in_ready is registered from the next count so there is no
// combinational path from out_ready to in_ready.
// Optional status block (level, almost_full, max_level, clr_stats) is built
// only when the macro DATA_PIPE_BUF_STATUS_EN is defined.
module data_pipe_buf
   import data_pipe_buf_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = 3
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        flush,
   input  logic                        in_valid,
   input  logic [WIDTH-1:0]            in_data,
   output logic                        in_ready,
   output logic                        out_valid,
   output logic [WIDTH-1:0]            out_data,
   input  logic                        out_ready
`ifdef DATA_PIPE_BUF_STATUS_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0]  level,
   output logic                        almost_full,
   output logic [$clog2(DEPTH+1)-1:0]  max_level,
   input  logic                        clr_stats
`endif
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
   logic [CW-1:0] count, count_next;
   xfer_t         xfer;
   logic          head_bypass;
   logic          head_load;

   assign xfer = '{push: in_valid & in_ready, pop: out_valid & out_ready, flush: flush};

   assign out_valid = (count != '0) ? 1'b1 : RST_VALID;

   // Incoming word becomes the head when nothing older remains after this cycle's pop
   assign head_bypass = xfer.push && (count == CW'(xfer.pop));
   // Refresh the head register whenever the buffer will hold a word; hold it otherwise
   assign head_load   = !xfer.flush && (count_next != '0);

   // Next-state pointers and count; flush discards any same-cycle push or pop
   always_comb begin
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      count_next  = count;
      if (xfer.flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (xfer.push) wr_ptr_next = wr_ptr + PW'(1);
         if (xfer.pop)  rd_ptr_next = rd_ptr + PW'(1);
         count_next = count + CW'(xfer.push) - CW'(xfer.pop);
      end
   end

   // Pointer, count and in_ready registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         in_ready <= RST_READY;
      end else begin
         wr_ptr   <= wr_ptr_next;
         rd_ptr   <= rd_ptr_next;
         count    <= count_next;
         in_ready <= (count_next < CW'(DEPTH));
      end
   end

   data_pipe_buf_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en     (xfer.push & ~xfer.flush),
      .wr_addr   (wr_ptr),
      .wr_data   (in_data),
      .rd_en     (head_load),
      .rd_addr   (rd_ptr_next),
      .rd_bypass (head_bypass),
      .rd_data   (out_data)
   );

`ifdef DATA_PIPE_BUF_STATUS_EN
   // Status registers: occupancy, almost-full flag and high-water mark
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level       <= '0;
         almost_full <= 1'b0;
         max_level   <= '0;
      end else begin
         level       <= count_next;
         almost_full <= (count_next >= CW'(AF_THRESH));
         if (clr_stats) begin
            max_level <= level;
         end else if (level > max_level) begin
            max_level <= level;
         end
      end
   end
`endif

endmodule

// File: tb/tb_data_pipe_buf.sv
// Directed bench for data_pipe_buf (WIDTH=8, DEPTH=4, AF_THRESH=3).
// Table of {inputs, expected outputs} rows plus hand-written sequences for
// reset, streaming, status counters and asynchronous reset mid-stream.
module tb_data_pipe_buf;

   logic       clk;
   logic       reset_n;
   logic       flush;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
`ifdef DATA_PIPE_BUF_STATUS_EN
   logic [2:0] level;
   logic       almost_full;
   logic [2:0] max_level;
   logic       clr_stats;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       ordy;
      logic       fl;
      logic       e_ir;
      logic       e_ov;
      logic [7:0] e_od;
      logic       chk_od;
   } vec_t;

   vec_t vecs[$];

   data_pipe_buf #(
      .WIDTH     (8),
      .DEPTH     (4),
      .AF_THRESH (3)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready)
`ifdef DATA_PIPE_BUF_STATUS_EN
      ,
      .level       (level),
      .almost_full (almost_full),
      .max_level   (max_level),
      .clr_stats   (clr_stats)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic iv, input logic [7:0] d, input logic ordy,
                               input logic fl, input logic e_ir, input logic e_ov,
                               input logic [7:0] e_od, input logic chk_od);
      vec_t v;
      v = '{iv, d, ordy, fl, e_ir, e_ov, e_od, chk_od};
      vecs.push_back(v);
   endfunction

   initial begin
      // Fill: push to full with a held-off 5th word
      add(1, 8'h11, 0, 0, 1, 1, 8'h11, 1);
      add(1, 8'h22, 0, 0, 1, 1, 8'h11, 1);
      add(1, 8'h33, 0, 0, 1, 1, 8'h11, 1);
      add(1, 8'h44, 0, 0, 0, 1, 8'h11, 1);
      add(1, 8'h55, 0, 0, 0, 1, 8'h11, 1);
      add(1, 8'h55, 0, 0, 0, 1, 8'h11, 1);
      // Drain in order; 0x55 must not appear
      add(0, 8'h00, 1, 0, 1, 1, 8'h22, 1);
      add(0, 8'h00, 1, 0, 1, 1, 8'h33, 1);
      add(0, 8'h00, 1, 0, 1, 1, 8'h44, 1);
      add(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
      // Three words, then flush together with push 0xAA and a pop
      add(1, 8'hA1, 0, 0, 1, 1, 8'hA1, 1);
      add(1, 8'hA2, 0, 0, 1, 1, 8'hA1, 1);
      add(1, 8'hA3, 0, 0, 1, 1, 8'hA1, 1);
      add(1, 8'hAA, 1, 1, 1, 0, 8'h00, 0);
      add(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
      add(1, 8'h5A, 0, 0, 1, 1, 8'h5A, 1);
      add(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);

      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
`ifdef DATA_PIPE_BUF_STATUS_EN
      clr_stats = 1'b0;
`endif

      // Reset held 5 cycles
      repeat (5) step();
      check("reset in_ready", in_ready, 0);
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
`ifdef DATA_PIPE_BUF_STATUS_EN
      check("reset level", level, 0);
      check("reset almost_full", almost_full, 0);
      check("reset max_level", max_level, 0);
`endif
      reset_n = 1'b1;
      step();
      check("post-reset in_ready", in_ready, 1);
      check("post-reset out_valid", out_valid, 0);

      // Table-driven rows
      for (int i = 0; i < vecs.size(); i++) begin
         in_valid  = vecs[i].iv;
         in_data   = vecs[i].d;
         out_ready = vecs[i].ordy;
         flush     = vecs[i].fl;
         step();
         check($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_ir);
         check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_ov);
         if (vecs[i].chk_od) check($sformatf("vec%0d out_data", i), out_data, vecs[i].e_od);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;

      // Streaming: one push and one pop per cycle, occupancy stays at 1
      for (int i = 0; i < 16; i++) begin
         in_valid  = 1'b1;
         in_data   = 8'(i);
         out_ready = 1'b1;
         step();
         check($sformatf("stream%0d out_valid", i), out_valid, 1);
         check($sformatf("stream%0d out_data", i), out_data, i);
         check($sformatf("stream%0d in_ready", i), in_ready, 1);
      end
      in_valid = 1'b0;
      step();
      check("stream drained out_valid", out_valid, 0);
      out_ready = 1'b0;

`ifdef DATA_PIPE_BUF_STATUS_EN
      // Status counters
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      check("stat clr max_level", max_level, 0);
      in_valid = 1'b1;
      in_data  = 8'h61;
      step();
      in_data = 8'h62;
      step();
      check("stat 2 almost_full", almost_full, 0);
      in_data = 8'h63;
      step();
      in_valid = 1'b0;
      check("stat 3 almost_full", almost_full, 1);
      check("stat 3 level", level, 3);
      out_ready = 1'b1;
      repeat (2) step();
      out_ready = 1'b0;
      check("stat pop2 level", level, 1);
      check("stat pop2 max_level", max_level, 3);
      check("stat pop2 almost_full", almost_full, 0);
      check("stat pop2 out_data", out_data, 8'h63);
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      check("stat clr2 max_level", max_level, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("stat empty out_valid", out_valid, 0);
`endif

      // Asynchronous reset with two words stored
      in_valid = 1'b1;
      in_data  = 8'h71;
      step();
      in_data = 8'h72;
      step();
      in_valid = 1'b0;
      check("pre-reset out_valid", out_valid, 1);
      check("pre-reset out_data", out_data, 8'h71);
      reset_n = 1'b0;
      #2;
      check("async reset out_valid", out_valid, 0);
      check("async reset in_ready", in_ready, 0);
      check("async reset out_data", out_data, 0);
      repeat (2) step();
      reset_n = 1'b1;
      step();
      check("rerelease in_ready", in_ready, 1);
      check("rerelease out_valid", out_valid, 0);
      in_valid = 1'b1;
      in_data  = 8'h7E;
      step();
      in_valid = 1'b0;
      check("after reset push out_data", out_data, 8'h7E);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("after reset pop out_valid", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
